bus_grant_encoder: RTL

Parametrised, registered successor to the combinational one-hot-to-binary bus-select encoder. Accepts N request lines from bus drivers (register-out enables, PC/MDR/HI/LO outs), picks exactly one winner by fixed or round-robin priority, and holds a registered binary index plus one-hot grant until the owner releases the bus. It sits between the control unit's out-enables and the bus multiplexer select. It removes undefined selects on zero-hot and multi-hot inputs.

---
 rtl/bus_grant_encoder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bus_grant_encoder.sv
// Registered bus-select arbiter: picks one of N requesters by fixed or round-robin
// priority and holds a binary index plus one-hot grant until the owner lets go.
module bus_grant_encoder #(
  parameter  int unsigned N     = 32,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic             release_bus,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N-1:0]     grant_onehot,
  output logic             grant_valid,
  output logic             contention,
  output logic             abort
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [N-1:0]     grant_onehot_q, grant_onehot_d;
  logic             grant_valid_q, grant_valid_d;
  logic             contention_q, contention_d;
  logic             abort_q, abort_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [IDX_W-1:0] winner_c;
  logic [IDX_W-1:0] ptr_next_c;
  logic             multi_c;

  // Lowest set index; the downward scan lets the lowest hit overwrite the rest.
  function automatic logic [IDX_W-1:0] pick_fixed(input logic [N-1:0] r);
    logic [IDX_W-1:0] w;
    w = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (r[IDX_W'(i)]) w = IDX_W'(i);
    end
    return w;
  endfunction

  // First set index starting at p, wrapping at N.
  function automatic logic [IDX_W-1:0] pick_rr(input logic [N-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] w;
    logic             found;
    int unsigned      j;
    w     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(p) + k;
      if (j >= N) j = j - N;
      if (!found && r[IDX_W'(j)]) begin
        found = 1'b1;
        w     = IDX_W'(j);
      end
    end
    return w;
  endfunction

  always_comb begin
    winner_c   = mode ? pick_rr(req, ptr_q) : pick_fixed(req);
    multi_c    = |(req & (req - N'(1)));
    ptr_next_c = (32'(grant_idx_q) + 32'd1 == N) ? '0 : grant_idx_q + IDX_W'(1);
  end

  always_comb begin
    state_d        = state_q;
    grant_idx_d    = grant_idx_q;
    grant_onehot_d = grant_onehot_q;
    grant_valid_d  = grant_valid_q;
    contention_d   = contention_q;
    abort_d        = 1'b0;
    ptr_d          = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d        = GRANT;
          grant_idx_d    = winner_c;
          grant_onehot_d = N'(1) << winner_c;
          grant_valid_d  = 1'b1;
          contention_d   = multi_c;
        end
      end
      GRANT: begin
        // A simultaneous drop and release is an ordinary release, not an abort.
        if (release_bus || !req[grant_idx_q]) begin
          state_d        = IDLE;
          grant_onehot_d = '0;
          grant_valid_d  = 1'b0;
          contention_d   = 1'b0;
          abort_d        = !release_bus;
          ptr_d          = ptr_next_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q        <= IDLE;
      grant_idx_q    <= '0;
      grant_onehot_q <= '0;
      grant_valid_q  <= 1'b0;
      contention_q   <= 1'b0;
      abort_q        <= 1'b0;
      ptr_q          <= '0;
    end else begin
      state_q        <= state_d;
      grant_idx_q    <= grant_idx_d;
      grant_onehot_q <= grant_onehot_d;
      grant_valid_q  <= grant_valid_d;
      contention_q   <= contention_d;
      abort_q        <= abort_d;
      ptr_q          <= ptr_d;
    end
  end

  assign grant_idx    = grant_idx_q;
  assign grant_onehot = grant_onehot_q;
  assign grant_valid  = grant_valid_q;
  assign contention   = contention_q;
  assign abort        = abort_q;

endmodule
